// File: rtl/ras_pkg.sv
// Shared types and default constants for the return-address-stack spill memory.
package ras_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ_WAIT,
      DONE
   } ras_mem_state_t;

   localparam logic [31:0] RAS_MEM_BASE  = 32'h0000_8000;
   localparam int          RAS_MEM_DEPTH = 64;
   // Wide enough for a latency down-counter covering RD_LAT up to 4.
   localparam int          RAS_MEM_CNT_W = 3;

endpackage

// File: rtl/ras_spill_ram.sv
// Single-port synchronous RAM with RD_LAT registered read stages; contents are never reset.
module ras_spill_ram #(
   parameter int W      = 32,
   parameter int DEPTH  = 64,
   parameter int RD_LAT = 2,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [W-1:0]  din_i,
   output logic [W-1:0]  dout_o
);

   logic [W-1:0] mem_q  [DEPTH];
   logic [W-1:0] pipe_q [RD_LAT];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= din_i;
      end
      pipe_q[0] <= mem_q[addr_i];
      for (int i = 1; i < RD_LAT; i++) begin
         pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign dout_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/ras_spill_mem.sv
// Spill memory for the encrypted return-address stack: one request at a time,
// window/alignment and protocol fault flags, and a write high-water mark.
module ras_spill_mem
   import ras_pkg::*;
#(
   parameter int           W      = 32,
   parameter int           DEPTH  = RAS_MEM_DEPTH,
   parameter logic [W-1:0] BASE   = W'(RAS_MEM_BASE),
   parameter int           RD_LAT = 2
) (
   input  logic                     clk,
   input  logic                     Rst,
   input  logic                     RAS_mem_rd,
   input  logic                     RAS_mem_wr,
   input  logic [W-1:0]             RAS_mem_addr,
   input  logic [W-1:0]             RAS_mem_din,
   output logic [W-1:0]             RAS_mem_dout,
   output logic                     RAS_mem_rdy,
   output logic                     mem_fault,
   output logic                     mem_proto_err,
   input  logic                     fault_clr,
   output logic [$clog2(DEPTH):0]   hwm
);

   localparam int AW = $clog2(DEPTH);
   localparam int HW = AW + 1;
   localparam int CW = RAS_MEM_CNT_W;

   ras_mem_state_t state_q, state_d;
   logic           rdy_q, rdy_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [W-1:0]   din_q, din_d;
   logic           bad_q, bad_d;
   logic [W-1:0]   dout_q, dout_d;
   logic           fault_q, fault_d;
   logic           proto_q, proto_d;
   logic [HW-1:0]  hwm_q, hwm_d;

   logic [W-1:0]   off_w;
   logic [W-1:0]   idx_w;
   logic           bad_w;
   logic           accept_w;
   logic           proto_w;
   logic           fault_set_w;
   logic [HW-1:0]  hwm_next_w;
   logic           ram_we_w;
   logic [W-1:0]   ram_dout_w;

   // Unsigned wrap of addr-BASE lets the index bound also catch most low addresses.
   assign off_w      = RAS_mem_addr - BASE;
   assign idx_w      = off_w >> 2;
   assign bad_w      = (RAS_mem_addr < BASE) || (idx_w >= W'(DEPTH)) ||
                       (RAS_mem_addr[1:0] != 2'b00);
   assign accept_w   = rdy_q && (RAS_mem_rd ^ RAS_mem_wr);
   assign proto_w    = rdy_q && RAS_mem_rd && RAS_mem_wr;
   assign hwm_next_w = {1'b0, addr_q} + HW'(1);
   assign ram_we_w   = (state_q == WRITE) && !bad_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      din_d       = din_q;
      bad_d       = bad_q;
      dout_d      = dout_q;
      hwm_d       = hwm_q;
      fault_set_w = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_w) begin
               addr_d      = idx_w[AW-1:0];
               din_d       = RAS_mem_din;
               bad_d       = bad_w;
               fault_set_w = bad_w;
               if (RAS_mem_wr) begin
                  state_d = WRITE;
               end else begin
                  state_d = READ_WAIT;
                  cnt_d   = CW'(RD_LAT - 1);
               end
            end
         end
         WRITE: begin
            state_d = IDLE;
            if (!bad_q && (hwm_next_w > hwm_q)) begin
               hwm_d = hwm_next_w;
            end
         end
         READ_WAIT: begin
            if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            dout_d  = bad_q ? '0 : ram_dout_w;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      rdy_d   = (state_d == IDLE);
      // A fault landing in the same cycle as fault_clr stays visible.
      fault_d = fault_set_w | (fault_q & ~fault_clr);
      proto_d = proto_w | (proto_q & ~fault_clr);
   end

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         state_q <= IDLE;
         rdy_q   <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         bad_q   <= 1'b0;
         dout_q  <= '0;
         fault_q <= 1'b0;
         proto_q <= 1'b0;
         hwm_q   <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         bad_q   <= bad_d;
         dout_q  <= dout_d;
         fault_q <= fault_d;
         proto_q <= proto_d;
         hwm_q   <= hwm_d;
      end
   end

   ras_spill_ram #(
      .W      (W),
      .DEPTH  (DEPTH),
      .RD_LAT (RD_LAT),
      .AW     (AW)
   ) u_ram (
      .clk    (clk),
      .we_i   (ram_we_w),
      .addr_i (addr_q),
      .din_i  (din_q),
      .dout_o (ram_dout_w)
   );

   assign RAS_mem_dout  = dout_q;
   assign RAS_mem_rdy   = rdy_q;
   assign mem_fault     = fault_q;
   assign mem_proto_err = proto_q;
   assign hwm           = hwm_q;

endmodule

// File: tb/tb_ras_spill_mem.sv
// Directed bench for ras_spill_mem with hand-computed expectations.
module tb_ras_spill_mem;

   logic        clk = 1'b0;
   logic        Rst;
   logic        rd, wr, fault_clr;
   logic [31:0] addr, din, dout;
   logic        rdy, fault, proto;
   logic [6:0]  hwm;

   int vectors = 0;
   int errs    = 0;

   ras_spill_mem dut (
      .clk           (clk),
      .Rst           (Rst),
      .RAS_mem_rd    (rd),
      .RAS_mem_wr    (wr),
      .RAS_mem_addr  (addr),
      .RAS_mem_din   (din),
      .RAS_mem_dout  (dout),
      .RAS_mem_rdy   (rdy),
      .mem_fault     (fault),
      .mem_proto_err (proto),
      .fault_clr     (fault_clr),
      .hwm           (hwm)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rdy();
      for (int i = 0; i < 20 && rdy !== 1'b1; i++) tick();
      if (rdy !== 1'b1) check("rdy_timeout", 32'(rdy), 32'd1);
   endtask

   // One request; returns how many sampled cycles rdy stayed low after accept.
   task automatic xact(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                       output int busy);
      wait_rdy();
      rd   = !is_wr;
      wr   = is_wr;
      addr = a;
      din  = d;
      tick();
      rd   = 1'b0;
      wr   = 1'b0;
      busy = 0;
      for (int i = 0; i < 20 && rdy !== 1'b1; i++) begin
         busy++;
         tick();
      end
   endtask

   initial begin
      int busy;
      int lowcnt;
      Rst       = 1'b1;
      rd        = 1'b0;
      wr        = 1'b0;
      fault_clr = 1'b0;
      addr      = '0;
      din       = '0;

      #12;
      check("rst_rdy",   32'(rdy),   32'd0);
      check("rst_dout",  dout,       32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_proto", 32'(proto), 32'd0);
      check("rst_hwm",   32'(hwm),   32'd0);
      @(negedge clk);
      Rst = 1'b0;
      #1;
      check("rdy_before_edge", 32'(rdy), 32'd0);
      tick();
      check("rdy_after_release", 32'(rdy), 32'd1);

      // Basic write then read
      xact(1'b1, 32'h0000_8000, 32'hDEAD_0001, busy);
      check("wr_busy", 32'(busy), 32'd1);
      xact(1'b0, 32'h0000_8000, 32'h0, busy);
      check("rd_busy", 32'(busy), 32'd3);
      check("rd_dout", dout, 32'hDEAD_0001);
      check("hwm_1",   32'(hwm), 32'd1);

      // Fill all 64 words, read back in reverse
      for (int i = 0; i < 64; i++) xact(1'b1, 32'h0000_8000 + 32'(4 * i), 32'(i + 1), busy);
      check("hwm_64", 32'(hwm), 32'd64);
      for (int i = 63; i >= 0; i--) begin
         xact(1'b0, 32'h0000_8000 + 32'(4 * i), 32'h0, busy);
         check($sformatf("fill_rd_%0d", i), dout, 32'(i + 1));
      end
      check("fill_fault", 32'(fault), 32'd0);

      // Out-of-window and misaligned accesses
      xact(1'b1, 32'h0000_8100, 32'hBEEF_BEEF, busy);
      check("oow_wr_busy", 32'(busy), 32'd1);
      check("oow_fault",   32'(fault), 32'd1);
      xact(1'b0, 32'h0000_7FFC, 32'h0, busy);
      check("low_rd_busy", 32'(busy), 32'd3);
      check("low_rd_dout", dout, 32'd0);
      xact(1'b0, 32'h0000_8002, 32'h0, busy);
      check("mis_rd_dout", dout, 32'd0);
      xact(1'b0, 32'h0000_8000, 32'h0, busy);
      check("w0_intact", dout, 32'd1);
      check("hwm_hold",  32'(hwm), 32'd64);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      check("fault_clr", 32'(fault), 32'd0);
      // Clear coinciding with a fault event: the fault wins
      wait_rdy();
      rd        = 1'b1;
      addr      = 32'h0000_8101;
      fault_clr = 1'b1;
      tick();
      rd        = 1'b0;
      fault_clr = 1'b0;
      check("set_wins", 32'(fault), 32'd1);
      wait_rdy();
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      check("fault_clr2", 32'(fault), 32'd0);

      // rd and wr together
      wait_rdy();
      rd   = 1'b1;
      wr   = 1'b1;
      addr = 32'h0000_8004;
      din  = 32'h0000_0BAD;
      tick();
      rd   = 1'b0;
      wr   = 1'b0;
      check("proto_set", 32'(proto), 32'd1);
      check("proto_rdy", 32'(rdy),   32'd1);
      xact(1'b0, 32'h0000_8004, 32'h0, busy);
      check("proto_ram", dout, 32'd2);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      check("proto_clr", 32'(proto), 32'd0);

      // Reset in the middle of a read
      xact(1'b1, 32'h0000_9000, 32'h0, busy);
      xact(1'b0, 32'h0000_8008, 32'h0, busy);
      check("pre_rst_dout", dout, 32'd3);
      wait_rdy();
      rd   = 1'b1;
      addr = 32'h0000_800C;
      tick();
      rd   = 1'b0;
      Rst  = 1'b1;
      #1;
      check("mid_rst_rdy",   32'(rdy),   32'd0);
      check("mid_rst_dout",  dout,       32'd0);
      check("mid_rst_fault", 32'(fault), 32'd0);
      check("mid_rst_hwm",   32'(hwm),   32'd0);
      #2;
      Rst = 1'b0;
      #1;
      check("mid_rst_rdy_low", 32'(rdy), 32'd0);
      tick();
      check("mid_rst_rdy_up", 32'(rdy), 32'd1);
      xact(1'b1, 32'h0000_8010, 32'h1234_5678, busy);
      xact(1'b0, 32'h0000_8010, 32'h0, busy);
      check("post_rst_rd",  dout, 32'h1234_5678);
      check("post_rst_hwm", 32'(hwm), 32'd5);

      // rd toggled while busy must be ignored
      wait_rdy();
      rd   = 1'b1;
      addr = 32'h0000_8010;
      tick();
      addr = 32'h0000_8000;
      rd   = 1'b0;
      tick();
      rd   = 1'b1;
      tick();
      rd   = 1'b0;
      tick();
      check("tog_done_rdy", 32'(rdy), 32'd1);
      check("tog_dout",     dout, 32'h1234_5678);
      lowcnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rdy !== 1'b1) lowcnt++;
      end
      check("tog_no_extra", 32'(lowcnt), 32'd0);
      check("tog_dout_hold", dout, 32'h1234_5678);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
